// File: rtl/adder_pkg.sv
// Shared types for the bit-serial adder family: FSM state encoding and op codes.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, reused bit-serially by the sequencing front-ends.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// WIDTH-bit add/subtract computed LSB first through one full_adder over WIDTH cycles,
// with valid/ready handshakes on the operand and result sides.
module bit_serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MSB  = CNT_W'(WIDTH - 2);

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   a_sr_reg, a_sr_next;
  logic [WIDTH-1:0]   b_sr_reg, b_sr_next;
  logic [WIDTH-1:0]   res_sr_reg, res_sr_next;
  logic               carry_reg, carry_next;
  logic               c_msb_reg, c_msb_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;

  logic fa_s;
  logic fa_c;

  full_adder u_fa (
    .a    (a_sr_reg[0]),
    .b    (b_sr_reg[0]),
    .cin  (carry_reg),
    .s    (fa_s),
    .cout (fa_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      a_sr_reg   <= '0;
      b_sr_reg   <= '0;
      res_sr_reg <= '0;
      carry_reg  <= 1'b0;
      c_msb_reg  <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      a_sr_reg   <= a_sr_next;
      b_sr_reg   <= b_sr_next;
      res_sr_reg <= res_sr_next;
      carry_reg  <= carry_next;
      c_msb_reg  <= c_msb_next;
      cnt_reg    <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    a_sr_next   = a_sr_reg;
    b_sr_next   = b_sr_reg;
    res_sr_next = res_sr_reg;
    carry_next  = carry_reg;
    c_msb_next  = c_msb_reg;
    cnt_next    = cnt_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
          a_sr_next   = a;
          b_sr_next   = (sub == OP_ADD) ? b : ~b;
          carry_next  = (sub == OP_SUB);
          cnt_next    = '0;
          res_sr_next = '0;
          state_next  = RUN;
        end
      end

      RUN: begin
        res_sr_next = {fa_s, res_sr_reg[WIDTH-1:1]};
        a_sr_next   = {1'b0, a_sr_reg[WIDTH-1:1]};
        b_sr_next   = {1'b0, b_sr_reg[WIDTH-1:1]};
        carry_next  = fa_c;
        // Carry into the MSB is kept so signed overflow can be formed at the end.
        if (cnt_reg == CNT_MSB) begin
          c_msb_next = fa_c;
        end
        if (cnt_reg == CNT_LAST) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign sum       = res_sr_reg;
  assign cout      = carry_reg;
  assign ovf       = c_msb_reg ^ carry_reg;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Randomized bench for bit_serial_adder_ctrl against an arithmetic reference model.
module tb_bit_serial_adder_ctrl;

  localparam int WIDTH = 8;
  localparam int SMAX  = (1 << (WIDTH - 1)) - 1;
  localparam int SMIN  = -(1 << (WIDTH - 1));

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit keep_valid = 1'b0;

  bit_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: {cout, ovf, sum} from plain unsigned and signed arithmetic.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic s);
    logic [WIDTH:0] full;
    int sx, sy, exact;
    logic v;
    if (s) full = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
    else   full = {1'b0, x} + {1'b0, y};
    sx = int'($signed(x));
    sy = int'($signed(y));
    exact = s ? (sx - sy) : (sx + sy);
    v = (exact > SMAX) || (exact < SMIN);
    return {full[WIDTH], v, full[WIDTH-1:0]};
  endfunction

  task automatic scramble();
    a   = WIDTH'($urandom);
    b   = WIDTH'($urandom);
    sub = 1'($urandom);
    if (!keep_valid) in_valid = 1'($urandom);
  endtask

  // Issue one operation at the next IDLE negedge; optionally hold the result under backpressure.
  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic s, input int hold, output int ov_cyc);
    int guard;
    int acc;
    logic [WIDTH+1:0] e;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("ready_timeout", 64'd0, 64'd1);
    a = x; b = y; sub = s;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    acc = cyc;
    e = model(x, y, s);
    guard = 0;
    do begin
      @(negedge clk);
      scramble();
      guard++;
    end while (!out_valid && guard < 40);
    if (guard >= 40) check("valid_timeout", 64'd0, 64'd1);
    ov_cyc = cyc;
    if (!keep_valid) in_valid = 1'b0;
    check("latency", 64'(cyc - acc), 64'd9);
    check("sum",  64'(sum),  64'(e[WIDTH-1:0]));
    check("cout", 64'(cout), 64'(e[WIDTH+1]));
    check("ovf",  64'(ovf),  64'(e[WIDTH]));
    $display("op %s a=0x%02h b=0x%02h -> sum=0x%02h cout=%0d ovf=%0d (exp 0x%02h %0d %0d)",
             s ? "sub" : "add", x, y, sum, cout, ovf, e[WIDTH-1:0], e[WIDTH+1], e[WIDTH]);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_sum",   64'(sum),       64'(e[WIDTH-1:0]));
      check("hold_ready", 64'(in_ready),  64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("consumed_valid", 64'(out_valid), 64'd0);
    check("consumed_ready", 64'(in_ready),  64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int oc;
    int prev;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum",       64'(sum),       64'd0);
    check("rst_cout",      64'(cout),      64'd0);
    check("rst_ovf",       64'(ovf),       64'd0);

    run_op(8'h5A, 8'h3C, 1'b0, 0, oc);
    run_op(8'hFF, 8'h01, 1'b0, 0, oc);
    run_op(8'h10, 8'h20, 1'b1, 0, oc);
    run_op(8'h80, 8'h01, 1'b1, 0, oc);
    run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 5, oc);

    // Reset in the middle of an operation.
    a = 8'hAB; b = 8'hCD; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_sum",       64'(sum),       64'd0);
    run_op(8'h01, 8'h01, 1'b0, 0, oc);

    for (int i = 0; i < 10; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), $urandom_range(0, 3), oc);
    end

    keep_valid = 1'b1;
    prev = -1;
    for (int i = 0; i < 20; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 0, oc);
      if (prev >= 0) check("b2b_spacing", 64'(oc - prev), 64'd10);
      prev = oc;
    end
    keep_valid = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
